// File: rtl/rps_match_scorer_if.sv
// Round handshake between the stone-paper-scissors judge and the scorer.
// The judge is the master; the scorer is the slave that raises round_ready.
interface rps_match_scorer_if;
    logic       round_valid;
    logic [1:0] round_result;
    logic       round_ready;

    modport master (
        output round_valid,
        output round_result,
        input  round_ready
    );

    modport slave (
        input  round_valid,
        input  round_result,
        output round_ready
    );
endinterface

// File: rtl/rps_match_scorer.sv
// Match scorekeeper: accumulates round results and declares a winner.
// Define RPS_ROUND_LIMIT_EN to end a drawn match after MAX_ROUNDS rounds.
module rps_match_scorer #(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4,
    parameter int MAX_ROUNDS = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               match_start,
    rps_match_scorer_if.slave  rnd,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] tie_count,
    output logic [SCORE_W-1:0] invalid_count,
    output logic [SCORE_W-1:0] round_count,
    output logic               match_active,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] CNT_MAX = '1;
    localparam logic [SCORE_W-1:0] TARGET  = SCORE_W'(WIN_TARGET);

    if (WIN_TARGET < 1 || WIN_TARGET > (2**SCORE_W) - 1) begin : g_bad_target
        $error("WIN_TARGET out of range");
    end
    if (MAX_ROUNDS < 1 || MAX_ROUNDS > (2**SCORE_W) - 1) begin : g_bad_rounds
        $error("MAX_ROUNDS out of range");
    end

`ifdef RPS_ROUND_LIMIT_EN
    localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(MAX_ROUNDS);
`endif

    state_t             state, state_n;
    logic [SCORE_W-1:0] p1_n, p2_n, tie_n, inv_n, rc_n;
    logic [1:0]         win_n;
    logic               done_n;

    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_n = state;
        p1_n    = p1_score;
        p2_n    = p2_score;
        tie_n   = tie_count;
        inv_n   = invalid_count;
        rc_n    = round_count;
        win_n   = match_winner;
        done_n  = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (match_start) begin
                    p1_n    = '0;
                    p2_n    = '0;
                    tie_n   = '0;
                    inv_n   = '0;
                    rc_n    = '0;
                    win_n   = 2'b00;
                    state_n = PLAY;
                end
            end
            PLAY: begin
                // A restart wins over a round presented in the same cycle
                if (match_start) begin
                    p1_n  = '0;
                    p2_n  = '0;
                    tie_n = '0;
                    inv_n = '0;
                    rc_n  = '0;
                    win_n = 2'b00;
                end else if (rnd.round_valid && rnd.round_ready) begin
                    rc_n = sat_inc(round_count);
                    unique case (rnd.round_result)
                        2'b00: tie_n = sat_inc(tie_count);
                        2'b01: p1_n  = p1_score + 1'b1;
                        2'b10: p2_n  = p2_score + 1'b1;
                        2'b11: inv_n = sat_inc(invalid_count);
                    endcase
                    if (p1_n == TARGET) begin
                        state_n = DONE;
                        win_n   = 2'b01;
                        done_n  = 1'b1;
                    end else if (p2_n == TARGET) begin
                        state_n = DONE;
                        win_n   = 2'b10;
                        done_n  = 1'b1;
                    end
`ifdef RPS_ROUND_LIMIT_EN
                    else if (rc_n == LIMIT) begin
                        state_n = DONE;
                        win_n   = 2'b00;
                        done_n  = 1'b1;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            p1_score        <= '0;
            p2_score        <= '0;
            tie_count       <= '0;
            invalid_count   <= '0;
            round_count     <= '0;
            match_winner    <= 2'b00;
            match_done      <= 1'b0;
            match_active    <= 1'b0;
            rnd.round_ready <= 1'b0;
        end else begin
            state           <= state_n;
            p1_score        <= p1_n;
            p2_score        <= p2_n;
            tie_count       <= tie_n;
            invalid_count   <= inv_n;
            round_count     <= rc_n;
            match_winner    <= win_n;
            match_done      <= done_n;
            match_active    <= (state_n == PLAY);
            rnd.round_ready <= (state_n == PLAY);
        end
    end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer: directed rounds, a per-cycle
// reference model of match rules, and literal checkpoints.
module tb_rps_match_scorer;

    localparam int T   = 3;
    localparam int W   = 4;
    localparam int MR  = 4;
    localparam int SAT = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         match_start;
    logic [W-1:0] p1_score, p2_score, tie_count, invalid_count, round_count;
    logic         match_active, match_done;
    logic [1:0]   match_winner;

    rps_match_scorer_if rnd ();

    rps_match_scorer #(
        .WIN_TARGET (T),
        .SCORE_W    (W),
        .MAX_ROUNDS (MR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .match_start   (match_start),
        .rnd           (rnd.slave),
        .p1_score      (p1_score),
        .p2_score      (p2_score),
        .tie_count     (tie_count),
        .invalid_count (invalid_count),
        .round_count   (round_count),
        .match_active  (match_active),
        .match_done    (match_done),
        .match_winner  (match_winner)
    );

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    bit check_en = 0;

    int m_p1 = 0, m_p2 = 0, m_tie = 0, m_inv = 0, m_rounds = 0;
    int m_winner = 0;
    bit m_play = 0, m_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int sat_add(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    task automatic m_clear();
        m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0;
        m_rounds = 0; m_winner = 0;
    endtask

    task automatic m_finish(input int who);
        m_winner = who;
        m_play   = 0;
        m_done   = 1;
    endtask

    // Reference model: match rules applied once per clock edge
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clear();
                m_play = 0;
                m_done = 0;
            end else begin
                m_done = 0;
                if (match_start) begin
                    m_clear();
                    m_play = 1;
                end else if (m_play && rnd.round_valid) begin
                    m_rounds = sat_add(m_rounds);
                    case (rnd.round_result)
                        2'b00: m_tie = sat_add(m_tie);
                        2'b01: m_p1 = m_p1 + 1;
                        2'b10: m_p2 = m_p2 + 1;
                        default: m_inv = sat_add(m_inv);
                    endcase
                    if (m_p1 == T) m_finish(1);
                    else if (m_p2 == T) m_finish(2);
`ifdef RPS_ROUND_LIMIT_EN
                    else if (m_rounds == MR) m_finish(0);
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("p1_score", p1_score, m_p1);
            chk("p2_score", p2_score, m_p2);
            chk("tie_count", tie_count, m_tie);
            chk("invalid_count", invalid_count, m_inv);
            chk("round_count", round_count, m_rounds);
            chk("match_winner", match_winner, m_winner);
            chk("match_done", match_done, m_done);
            chk("match_active", match_active, m_play);
            chk("round_ready", rnd.round_ready, m_play);
            if (match_done === 1'b1) done_seen++;
        end
    end

    task automatic drive(input bit s, input bit v, input logic [1:0] r);
        match_start      = s;
        rnd.round_valid  = v;
        rnd.round_result = r;
        @(posedge clk);
        #1;
        match_start     = 1'b0;
        rnd.round_valid = 1'b0;
    endtask

    task automatic play(input logic [1:0] r);
        drive(1'b0, 1'b1, r);
    endtask

    int d0;

    initial begin
        rst_n            = 1'b1;
        match_start      = 1'b0;
        rnd.round_valid  = 1'b0;
        rnd.round_result = 2'b00;
        #3 rst_n = 1'b0;
        #14 rst_n = 1'b1;
        check_en = 1;

        chk("reset ready", rnd.round_ready, 0);
        chk("reset active", match_active, 0);
        chk("reset p1", p1_score, 0);

        // Test 1: P1 sweeps three rounds
        drive(1'b1, 1'b0, 2'b00);
        chk("t1 active", match_active, 1);
        d0 = done_seen;
        play(2'b01);
        play(2'b01);
        play(2'b01);
        chk("t1 p1", p1_score, 3);
        chk("t1 p2", p2_score, 0);
        chk("t1 winner", match_winner, 1);
        chk("t1 done hi", match_done, 1);
        drive(1'b0, 1'b0, 2'b00);
        chk("t1 done lo", match_done, 0);
        chk("t1 ready", rnd.round_ready, 0);
        drive(1'b0, 1'b0, 2'b00);
        chk("t1 one pulse", done_seen - d0, 1);

        // Test 2: mixed rounds, P2 wins
        drive(1'b1, 1'b0, 2'b00);
        play(2'b10);
        play(2'b00);
        play(2'b11);
        play(2'b10);
        play(2'b01);
        play(2'b10);
        chk("t2 p2", p2_score, 3);
        chk("t2 p1", p1_score, 1);
        chk("t2 tie", tie_count, 1);
        chk("t2 inv", invalid_count, 1);
        chk("t2 rounds", round_count, 6);
        chk("t2 winner", match_winner, 2);

        // Test 3: rounds ignored in DONE, then restart
        for (int i = 0; i < 5; i++) play(2'b01);
        chk("t3 p1 hold", p1_score, 1);
        chk("t3 rounds hold", round_count, 6);
        chk("t3 winner hold", match_winner, 2);
        drive(1'b1, 1'b0, 2'b00);
        chk("t3 p2 clr", p2_score, 0);
        chk("t3 rounds clr", round_count, 0);
        chk("t3 winner clr", match_winner, 0);
        chk("t3 active", match_active, 1);

        // Test 4: restart beats a concurrent round
        play(2'b01);
        play(2'b01);
        chk("t4 p1 pre", p1_score, 2);
        d0 = done_seen;
        drive(1'b1, 1'b1, 2'b01);
        chk("t4 p1", p1_score, 0);
        chk("t4 rounds", round_count, 0);
        chk("t4 active", match_active, 1);
        drive(1'b0, 1'b0, 2'b00);
        chk("t4 no done", done_seen - d0, 0);

        // Test 6: four ties against the round cap
        drive(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) play(2'b00);
        chk("t6 tie", tie_count, 4);
`ifdef RPS_ROUND_LIMIT_EN
        chk("t6 done", match_done, 1);
        chk("t6 winner", match_winner, 0);
        chk("t6 active", match_active, 0);
`else
        chk("t6 done", match_done, 0);
        chk("t6 active", match_active, 1);
        for (int i = 0; i < 12; i++) play(2'b00);
        chk("sat tie", tie_count, 15);
        chk("sat rounds", round_count, 15);
        play(2'b01);
        chk("sat rounds hold", round_count, 15);
        chk("sat p1", p1_score, 1);
`endif

        // Test 5: asynchronous reset mid-match
        drive(1'b1, 1'b0, 2'b00);
        play(2'b01);
        play(2'b10);
        chk("t5 p1 pre", p1_score, 1);
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 p1", p1_score, 0);
        chk("t5 p2", p2_score, 0);
        chk("t5 rounds", round_count, 0);
        chk("t5 active", match_active, 0);
        chk("t5 ready", rnd.round_ready, 0);
        chk("t5 done", match_done, 0);
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 idle", match_active, 0);
        drive(1'b0, 1'b1, 2'b01);
        chk("t5 idle ignores", p1_score, 0);
        chk("t5 no done", done_seen - d0, 0);

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
